// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port synchronous data memory between the MEM stage (port A)
// and a loader/debug requester (port B). Reads take an issue cycle and a return cycle.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_read_i,
    input  logic              a_write_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic [DATA_W-1:0] a_rdata_o,
    output logic              stall_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_ack_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        state_dbg_o,
    output logic [CNT_W-1:0]  starve_cnt_dbg_o
);
    // Handshake: port A is accepted in any cycle where an A request is present and
    // stall_o=0 (read data is valid on a_rdata_o in that cycle); port B is complete
    // in the cycle b_ack_o=1, and the requester holds b_req_i and its fields until then.
    typedef enum logic [1:0] {IDLE = 2'd0, A_RD = 2'd1, B_RD = 2'd2} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t            state, next_state;
    logic [CNT_W-1:0]  starve_cnt;
    logic [DATA_W-1:0] a_hold, b_hold;

    logic              a_req, b_issue, a_cap, b_cap;
    logic              en_c, we_c, stall_c, ack_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c, a_rdata_c, b_rdata_c;

    assign a_req = a_read_i | a_write_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            a_hold     <= '0;
            b_hold     <= '0;
        end else begin
            state <= next_state;
            if (a_cap) a_hold <= mem_rdata_i;
            if (b_cap) b_hold <= mem_rdata_i;
            // The return cycle of B neither ages nor clears the counter.
            if (!b_req_i || b_issue)
                starve_cnt <= '0;
            else if (state != B_RD && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        en_c       = 1'b0;
        we_c       = 1'b0;
        addr_c     = '0;
        wdata_c    = '0;
        stall_c    = 1'b0;
        ack_c      = 1'b0;
        b_issue    = 1'b0;
        a_cap      = 1'b0;
        b_cap      = 1'b0;
        a_rdata_c  = a_hold;
        b_rdata_c  = b_hold;
        case (state)
            IDLE: begin
                if (b_req_i && (starve_cnt == LIMIT || !a_req)) begin
                    b_issue = 1'b1;
                    en_c    = 1'b1;
                    we_c    = b_we_i;
                    addr_c  = b_addr_i;
                    wdata_c = b_wdata_i;
                    stall_c = a_req;
                    if (b_we_i) ack_c = 1'b1;
                    else        next_state = B_RD;
                end else if (a_req) begin
                    en_c    = 1'b1;
                    we_c    = a_write_i;
                    addr_c  = a_addr_i;
                    wdata_c = a_wdata_i;
                    // A write has priority over a simultaneous read and completes now.
                    if (!a_write_i) begin
                        stall_c    = 1'b1;
                        next_state = A_RD;
                    end
                end
            end
            A_RD: begin
                a_rdata_c  = mem_rdata_i;
                a_cap      = 1'b1;
                next_state = IDLE;
            end
            B_RD: begin
                ack_c      = 1'b1;
                b_rdata_c  = mem_rdata_i;
                b_cap      = 1'b1;
                stall_c    = a_req;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Every output is forced low while reset is held, including the pass-through paths.
    assign mem_en_o         = rst & en_c;
    assign mem_we_o         = rst & we_c;
    assign mem_addr_o       = rst ? addr_c : '0;
    assign mem_wdata_o      = rst ? wdata_c : '0;
    assign stall_o          = rst & stall_c;
    assign b_ack_o          = rst & ack_c;
    assign a_rdata_o        = rst ? a_rdata_c : '0;
    assign b_rdata_o        = rst ? b_rdata_c : '0;
    assign state_dbg_o      = state;
    assign starve_cnt_dbg_o = starve_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random two-port traffic, with a
// word-level memory model feeding expected-response queues checked by a monitor.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int CW = $clog2(SL + 1);

    logic          clk, rst;
    logic          a_read_i, a_write_i, b_req_i, b_we_i;
    logic [AW-1:0] a_addr_i, b_addr_i;
    logic [DW-1:0] a_wdata_i, b_wdata_i;
    logic [DW-1:0] a_rdata_o, b_rdata_o, mem_wdata_o, mem_rdata_i;
    logic          stall_o, b_ack_o, mem_en_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [1:0]    state_dbg_o;
    logic [CW-1:0] starve_cnt_dbg_o;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .a_read_i(a_read_i), .a_write_i(a_write_i), .a_addr_i(a_addr_i),
        .a_wdata_i(a_wdata_i), .a_rdata_o(a_rdata_o), .stall_o(stall_o),
        .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i),
        .b_wdata_i(b_wdata_i), .b_ack_o(b_ack_o), .b_rdata_o(b_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .state_dbg_o(state_dbg_o), .starve_cnt_dbg_o(starve_cnt_dbg_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory behind the arbiter ----------------
    logic [DW-1:0] ram [128];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) ram[mem_addr_o[8:2]] <= mem_wdata_o;
            else          ram_q <= ram[mem_addr_o[8:2]];
        end
    end
    assign mem_rdata_i = ram_q;

    // ---------------- scoreboard ----------------
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] model_mem [128];
    logic [DW-1:0] a_exp_q [$];
    logic [DW:0]   b_exp_q [$];   // MSB set: read, compare data

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever either port completes.
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (a_read_i && !a_write_i && !stall_o) begin
                    if (a_exp_q.size() == 0) chk("a_unexpected_return", 1, 0);
                    else chk("a_rdata", a_rdata_o, a_exp_q.pop_front());
                end
                if (b_ack_o) begin
                    chk("b_ack_with_req", b_req_i, 1);
                    if (b_exp_q.size() == 0) chk("b_unexpected_ack", 1, 0);
                    else begin
                        e = b_exp_q.pop_front();
                        if (e[DW]) chk("b_rdata", b_rdata_o, e[DW-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic a_drive(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, output int stalls,
                           output logic en0, output logic we0);
        logic [6:0] idx;
        int         c;
        logic       done;
        idx = addr[8:2];
        if (wr)      model_mem[idx] = data;
        else if (rd) a_exp_q.push_back(model_mem[idx]);
        a_read_i = rd; a_write_i = wr; a_addr_i = addr; a_wdata_i = data;
        stalls = 0; en0 = 1'b0; we0 = 1'b0; c = 0; done = 1'b0;
        while (!done && c < 40) begin
            @(negedge clk);
            if (c == 0) begin en0 = mem_en_o; we0 = mem_we_o; end
            if (!stall_o) done = 1'b1;
            else stalls++;
            c++;
        end
        if (!done) chk("a_accept_timeout", 0, 1);
        @(posedge clk); #1;
        a_read_i = 1'b0; a_write_i = 1'b0;
    endtask

    task automatic b_drive(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           output int lat, output logic stall_seen, output logic stall_issue,
                           output logic [DW-1:0] wd_ack, output int max_cnt);
        logic [6:0] idx;
        logic       done, prev;
        idx = addr[8:2];
        if (we) begin
            model_mem[idx] = data;
            b_exp_q.push_back({1'b0, data});
        end else b_exp_q.push_back({1'b1, model_mem[idx]});
        b_req_i = 1'b1; b_we_i = we; b_addr_i = addr; b_wdata_i = data;
        lat = 0; stall_seen = 1'b0; stall_issue = 1'b0; wd_ack = '0; max_cnt = 0;
        done = 1'b0; prev = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (stall_o) stall_seen = 1'b1;
            if (int'(starve_cnt_dbg_o) > max_cnt) max_cnt = int'(starve_cnt_dbg_o);
            if (b_ack_o) begin
                done = 1'b1;
                wd_ack = mem_wdata_o;
                stall_issue = we ? stall_o : prev;
            end
            prev = stall_o;
        end
        if (!done) chk("b_ack_timeout", 0, 1);
        @(posedge clk); #1;
        b_req_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            s1, s2, s3, lat, mc;
        logic          e0, w0, ss, si;
        logic [DW-1:0] wd;

        for (int i = 0; i < 128; i++) begin
            model_mem[i] = $urandom;
            ram[i] = model_mem[i];
        end
        model_mem[8] = 32'h1234_5678;  // word at 0x20
        ram[8] = 32'h1234_5678;
        ram_q = '0;

        // Reset with busy-looking inputs: every output must read zero.
        rst = 1'b1;
        #1 rst = 1'b0;
        a_read_i = 1'b1; a_write_i = 1'b1; a_addr_i = 32'h44; a_wdata_i = 32'hFFFF_FFFF;
        b_req_i = 1'b1; b_we_i = 1'b1; b_addr_i = 32'h48; b_wdata_i = 32'hAAAA_5555;
        #12;
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_b_ack", b_ack_o, 0);
        chk("rst_a_rdata", a_rdata_o, 0);
        chk("rst_b_rdata", b_rdata_o, 0);
        a_read_i = 1'b0; a_write_i = 1'b0; b_req_i = 1'b0; b_we_i = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_state", state_dbg_o, 0);
        chk("rst_starve", starve_cnt_dbg_o, 0);

        // A write then A read of 0x10.
        a_drive(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, s1, e0, w0);
        chk("a_wr_stalls", s1, 0);
        chk("a_wr_en", e0, 1);
        chk("a_wr_we", w0, 1);
        a_drive(1'b1, 1'b0, 32'h10, '0, s1, e0, w0);
        chk("a_rd_stalls", s1, 1);
        chk("a_rd_en", e0, 1);
        chk("a_rd_we", w0, 0);

        // B read of preloaded 0x20 with A idle.
        b_drive(1'b0, 32'h20, '0, lat, ss, si, wd, mc);
        chk("b_rd_latency", lat, 2);
        chk("b_rd_no_stall", ss, 0);
        b_drive(1'b1, 32'h24, 32'h0BAD_F00D, lat, ss, si, wd, mc);
        chk("b_wr_latency", lat, 1);

        // Continuous A reads starve B until the limit forces a grant.
        fork
            begin
                a_drive(1'b1, 1'b0, 32'h40, '0, s1, e0, w0);
                a_drive(1'b1, 1'b0, 32'h44, '0, s2, e0, w0);
                a_drive(1'b1, 1'b0, 32'h24, '0, s3, e0, w0);
            end
            b_drive(1'b0, 32'h20, '0, lat, ss, si, wd, mc);
        join
        chk("starve_a1_stalls", s1, 1);
        chk("starve_a2_stalls", s2, 1);
        chk("starve_a3_stalls", s3, 3);
        chk("starve_b_latency", lat, 6);
        chk("starve_cnt_max", mc, SL);
        chk("starve_b_issue_stall", si, 1);

        // Read and write together: write only.
        a_drive(1'b1, 1'b1, 32'h30, 32'h3030_C0C0, s1, e0, w0);
        chk("rdwr_stalls", s1, 0);
        chk("rdwr_we", w0, 1);
        chk("rdwr_state_idle", state_dbg_o, 0);
        a_drive(1'b1, 1'b0, 32'h30, '0, s1, e0, w0);

        // Reset during the A read return cycle.
        a_read_i = 1'b1; a_addr_i = 32'h10;
        @(posedge clk); #1;
        chk("pre_rst_state_ard", state_dbg_o, 1);
        rst = 1'b0;
        #1;
        chk("ard_rst_a_rdata", a_rdata_o, 0);
        chk("ard_rst_stall", stall_o, 0);
        chk("ard_rst_mem_en", mem_en_o, 0);
        chk("ard_rst_state", state_dbg_o, 0);
        a_read_i = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_a_hold", a_rdata_o, 0);
        @(posedge clk); #1;
        a_drive(1'b1, 1'b0, 32'h10, '0, s1, e0, w0);
        chk("post_rst_rd_stalls", s1, 1);

        // Simultaneous A write and B write, counter at zero.
        fork
            a_drive(1'b0, 1'b1, 32'h50, 32'h5050_5050, s1, e0, w0);
            b_drive(1'b1, 32'h28, 32'h2828_ABCD, lat, ss, si, wd, mc);
        join
        chk("dual_wr_a_stalls", s1, 0);
        chk("dual_wr_b_latency", lat, 2);
        chk("dual_wr_b_wdata", wd, 32'h2828_ABCD);

        // Random traffic: A in words 0..63, B in words 64..127.
        fork
            for (int n = 0; n < 150; n++) begin
                int op, gap;
                op = $urandom_range(0, 3);
                gap = $urandom_range(0, 2);
                a_drive(op < 2 || op == 3, op >= 2, 32'(4 * $urandom_range(0, 63)), $urandom,
                        s1, e0, w0);
                chk("rand_a_stall_bound", s1 <= 3, 1);
                if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
            end
            for (int n = 0; n < 60; n++) begin
                int gap;
                gap = $urandom_range(0, 3);
                b_drive(1'($urandom_range(0, 1)), 32'(256 + 4 * $urandom_range(0, 63)), $urandom,
                        lat, ss, si, wd, mc);
                chk("rand_b_latency_bound", lat <= SL + 3, 1);
                if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
            end
        join

        // Cross-port read-back once traffic has drained.
        for (int i = 0; i < 8; i++) begin
            b_drive(1'b0, 32'(4 * i * 7), '0, lat, ss, si, wd, mc);
            a_drive(1'b1, 1'b0, 32'(256 + 4 * i * 7), '0, s1, e0, w0);
        end

        repeat (3) @(posedge clk);
        chk("a_queue_drained", a_exp_q.size(), 0);
        chk("b_queue_drained", b_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port synchronous data memory between the MEM stage (port A, lw/sw) and a loader/debug requester (port B). It sequences each access into issue and read-return cycles. It stalls the pipeline while a MEM-stage read is outstanding or while port B holds the memory. A starvation counter guarantees that port B progresses under continuous pipeline traffic.

## Interface
Parameters:
- ADDR_W, 32, byte address width; passed unchanged to memory
- DATA_W, 32, data width
- STARVE_LIMIT, 4, cycles port B may wait under A traffic before it is forced a grant (≥1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- a_read_i  in  1  MEM-stage lw (MemRead)
- a_write_i  in  1  MEM-stage sw (MemWrite)
- a_addr_i  in  ADDR_W  ALU result address
- a_wdata_i  in  DATA_W  rt store data
- a_rdata_o  out  DATA_W  lw data to MEM/WB
- stall_o  out  1  freeze PC/IF/ID/EX/EX-MEM; A inputs held stable while 1
- b_req_i  in  1  port B request; held until b_ack_o
- b_we_i  in  1  port B write(1)/read(0)
- b_addr_i  in  ADDR_W  port B address
- b_wdata_i  in  DATA_W  port B write data
- b_ack_o  out  1  one-cycle completion pulse
- b_rdata_o  out  DATA_W  port B read data
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  read data, valid the cycle after a read strobe

## Operation
- States: IDLE, A_RD, B_RD. Memory is driven only from IDLE. A_RD and B_RD are return cycles with mem_en_o=0.
- A request = a_read_i | a_write_i. If both are set, write wins and no read data is returned.
- IDLE arbitration, evaluated in priority order:
  - b_req_i & starve_cnt==STARVE_LIMIT: issue B.
  - A request: issue A.
  - b_req_i: issue B.
  - Otherwise: no access.
- Issue A write: mem_en=1, mem_we=1, stall_o=0. Stay IDLE; the store completes this cycle.
- Issue A read: mem_en=1, mem_we=0, stall_o=1. Go to A_RD.
- A_RD:
  - stall_o=0.
  - a_rdata_o = mem_rdata_i, which is also captured into the A hold register.
  - Next state is IDLE. The held instruction is not reissued.
- Issue B write: mem_we=1 and b_ack_o=1 the same cycle. Stay IDLE.
- Issue B read: go to B_RD. In B_RD, b_ack_o=1 and b_rdata_o = mem_rdata_i (also captured). Next state is IDLE.
- Whenever B is issued while an A request is present, stall_o=1 for that cycle.
- stall_o=1 whenever an A request is present in IDLE and not issued. A B_RD cycle with an A request present also gives stall_o=1.
- Outside the return cycles, a_rdata_o and b_rdata_o show their hold registers.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, each IDLE/A_RD cycle with b_req_i=1 and B not issued.
  - Cleared when B is issued or b_req_i=0.
- A back-to-back B request (b_req_i still 1 after ack) is a new transfer, arbitrated normally.

## Timing
- Reset (rst=0, asynchronous):
  - State IDLE, starve_cnt=0, hold registers 0.
  - All outputs 0 while rst=0: mem_en, mem_we, mem_addr, mem_wdata, stall, b_ack, a_rdata, b_rdata.
- Reset asserted in A_RD or B_RD abandons the return: no ack, hold register unchanged (i.e. 0).
- A write: 1 cycle, no stall. A read: 2 cycles, stall in cycle 0 only, data in cycle 1.
- B write: ack in issue cycle. B read: ack one cycle after issue.
- Worst-case A delay from B traffic: one B access (2 cycles for a read) per STARVE_LIMIT+1 A-busy cycles.
- Memory outputs are combinational from state and inputs. Only the 2-bit state, starve_cnt, and hold registers are flops.

## Test plan
- Reset, then an A write to 0x10 with data 0xDEADBEEF: mem_en=mem_we=1 the same cycle, stall_o=0. An A read of 0x10 then gives stall_o=1 for 1 cycle, then a_rdata_o=0xDEADBEEF with stall_o=0.
- Idle A, B read of 0x20 (preloaded 0x12345678): b_ack_o pulses exactly in cycle 2 with b_rdata_o=0x12345678. No stall at any time.
- Continuous A reads with b_req_i held (STARVE_LIMIT=4): starve_cnt reaches 4. B is then issued with stall_o=1 that cycle. The starved A read resumes next IDLE and its data is correct.
- a_read_i=a_write_i=1 at 0x30: a single write strobe, no A_RD state, stall_o=0.
- Assert rst during A_RD: all outputs go 0 immediately. After release, state is IDLE and a fresh A read completes normally in 2 cycles.
- Simultaneous B write and A write with starve_cnt=0: A is issued and B waits. B is issued the next free cycle with b_ack_o=1 and mem_wdata_o=b_wdata_i.
